// File: rtl/tff_pkg.sv
// rtl/tff_pkg.sv - shared mode encoding for the toggle/counter register bank
package tff_pkg;

   // Operation select carried on the mode field of the control interface.
   typedef enum logic [1:0] {
      MODE_TOGGLE = 2'b00,
      MODE_UP     = 2'b01,
      MODE_DOWN   = 2'b10,
      MODE_LOAD   = 2'b11
   } tff_mode_t;

endpackage

// File: rtl/tff_counter_if.sv
// rtl/tff_counter_if.sv - control and status bundle for tff_counter
interface tff_counter_if
   import tff_pkg::*;
#(
   parameter int WIDTH = 8
);

   logic             en;
   tff_mode_t        mode;
   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic             ovf;
   logic             zero;

   // The controlling side drives operation and operands, observes state.
   modport master (
      output en, mode, t, d,
      input  q, ovf, zero
   );

   // The register bank consumes operation and operands, reports state.
   modport slave (
      input  en, mode, t, d,
      output q, ovf, zero
   );

endinterface

// File: rtl/tff_counter.sv
// rtl/tff_counter.sv - WIDTH-bit masked toggle bank / up-down counter with limit pulse
module tff_counter
   import tff_pkg::*;
#(
   parameter int               WIDTH    = 8,
   parameter bit               SATURATE = 1'b0,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic         clk,
   input  logic         rst,
   tff_counter_if.slave bus
);

   localparam logic [WIDTH-1:0] MAX_VAL = '1;
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   // Limit compares are made once on the current state and shared by the
   // counting limits and the zero flag.
   logic at_max;
   logic at_zero;

   assign at_max   = (bus.q == MAX_VAL);
   assign at_zero  = (bus.q == '0);
   assign bus.zero = at_zero;

   // State and boundary pulse: reset, then enable, then the sampled mode.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bus.q   <= RST_VAL;
         bus.ovf <= 1'b0;
      end else if (!bus.en) begin
         bus.ovf <= 1'b0;
      end else begin
         case (bus.mode)
            MODE_TOGGLE: begin
               bus.q   <= bus.q ^ bus.t;
               bus.ovf <= 1'b0;
            end
            MODE_UP: begin
               if (at_max) begin
                  // Saturating counters park at the limit but keep flagging it.
                  bus.q   <= SATURATE ? MAX_VAL : '0;
                  bus.ovf <= 1'b1;
               end else begin
                  bus.q   <= bus.q + ONE;
                  bus.ovf <= 1'b0;
               end
            end
            MODE_DOWN: begin
               if (at_zero) begin
                  bus.q   <= SATURATE ? '0 : MAX_VAL;
                  bus.ovf <= 1'b1;
               end else begin
                  bus.q   <= bus.q - ONE;
                  bus.ovf <= 1'b0;
               end
            end
            default: begin
               // A load is never a boundary event, even when d is a limit.
               bus.q   <= bus.d;
               bus.ovf <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tff_counter.sv
// tb/tb_tff_counter.sv - self-checking bench for tff_counter across three configurations
module tb_tff_counter;
   import tff_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Per-instance stimulus: 0 = W4 wrap RST 5, 1 = W4 saturate RST 0, 2 = W1 wrap RST 0
   logic       rst_v  [3];
   logic       en_v   [3];
   tff_mode_t  mode_v [3];
   logic [3:0] t_v    [3];
   logic [3:0] d_v    [3];

   logic rst0, rst1, rst2;
   assign rst0 = rst_v[0];
   assign rst1 = rst_v[1];
   assign rst2 = rst_v[2];

   tff_counter_if #(.WIDTH(4)) if0 ();
   tff_counter_if #(.WIDTH(4)) if1 ();
   tff_counter_if #(.WIDTH(1)) if2 ();

   assign if0.en = en_v[0];  assign if0.mode = mode_v[0];
   assign if0.t  = t_v[0];   assign if0.d    = d_v[0];
   assign if1.en = en_v[1];  assign if1.mode = mode_v[1];
   assign if1.t  = t_v[1];   assign if1.d    = d_v[1];
   assign if2.en = en_v[2];  assign if2.mode = mode_v[2];
   assign if2.t  = t_v[2][0:0];
   assign if2.d  = d_v[2][0:0];

   tff_counter #(.WIDTH(4), .SATURATE(1'b0), .RST_VAL(4'h5)) u_dut0 (.clk(clk), .rst(rst0), .bus(if0));
   tff_counter #(.WIDTH(4), .SATURATE(1'b1), .RST_VAL(4'h0)) u_dut1 (.clk(clk), .rst(rst1), .bus(if1));
   tff_counter #(.WIDTH(1), .SATURATE(1'b0), .RST_VAL(1'b0)) u_dut2 (.clk(clk), .rst(rst2), .bus(if2));

   // Reference model: plain integer arithmetic over the value range.
   int cfg_w [3] = '{4, 4, 1};
   int cfg_s [3] = '{0, 1, 0};
   int cfg_r [3] = '{5, 0, 0};
   int mq [3];
   int mo [3];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model(input int k);
      int top;
      int nq;
      top = (1 << cfg_w[k]) - 1;
      if (!rst_v[k]) begin
         mq[k] = cfg_r[k];
         mo[k] = 0;
      end else if (!en_v[k]) begin
         mo[k] = 0;
      end else begin
         case (mode_v[k])
            MODE_TOGGLE: begin
               mq[k] = mq[k] ^ (int'(t_v[k]) & top);
               mo[k] = 0;
            end
            MODE_UP: begin
               nq = mq[k] + 1;
               if (nq > top) begin
                  mo[k] = 1;
                  mq[k] = (cfg_s[k] != 0) ? top : nq - (top + 1);
               end else begin
                  mo[k] = 0;
                  mq[k] = nq;
               end
            end
            MODE_DOWN: begin
               nq = mq[k] - 1;
               if (nq < 0) begin
                  mo[k] = 1;
                  mq[k] = (cfg_s[k] != 0) ? 0 : nq + (top + 1);
               end else begin
                  mo[k] = 0;
                  mq[k] = nq;
               end
            end
            default: begin
               mq[k] = int'(d_v[k]) & top;
               mo[k] = 0;
            end
         endcase
      end
   endtask

   task automatic setv(input int k, input logic r, input logic e, input tff_mode_t m,
                       input logic [3:0] tt, input logic [3:0] dd);
      rst_v[k]  = r;
      en_v[k]   = e;
      mode_v[k] = m;
      t_v[k]    = tt;
      d_v[k]    = dd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) model(k);
      chk("q0",    if0.q,    mq[0]);
      chk("ovf0",  if0.ovf,  mo[0]);
      chk("zero0", if0.zero, (mq[0] == 0));
      chk("q1",    if1.q,    mq[1]);
      chk("ovf1",  if1.ovf,  mo[1]);
      chk("zero1", if1.zero, (mq[1] == 0));
      chk("q2",    if2.q,    mq[2]);
      chk("ovf2",  if2.ovf,  mo[2]);
      chk("zero2", if2.zero, (mq[2] == 0));
   endtask

   initial begin
      // Reset held with UP enabled for three edges.
      for (int k = 0; k < 3; k++) setv(k, 1'b0, 1'b1, MODE_UP, 4'h0, 4'h0);
      repeat (3) step();
      chk("rst_q0", if0.q, 4'h5);
      chk("rst_zero0", if0.zero, 1'b0);
      chk("rst_zero1", if1.zero, 1'b1);

      // Release reset with enable low: hold.
      for (int k = 0; k < 3; k++) setv(k, 1'b1, 1'b0, MODE_UP, 4'h0, 4'h0);
      repeat (2) step();
      chk("hold_q0", if0.q, 4'h5);

      // Toggle mask sequence.
      setv(0, 1'b1, 1'b1, MODE_LOAD, 4'h0, 4'h0);    step();
      setv(0, 1'b1, 1'b1, MODE_TOGGLE, 4'hA, 4'h7);  step();
      chk("tgl_a", if0.q, 4'hA);
      setv(0, 1'b1, 1'b1, MODE_TOGGLE, 4'h3, 4'h7);  step();
      chk("tgl_3", if0.q, 4'h9);
      setv(0, 1'b1, 1'b1, MODE_TOGGLE, 4'h0, 4'h7);  step();
      chk("tgl_0", if0.q, 4'h9);

      // Wrap counting.
      setv(0, 1'b1, 1'b1, MODE_LOAD, 4'h0, 4'hE);    step();
      setv(0, 1'b1, 1'b1, MODE_UP, 4'h0, 4'h0);
      step();
      chk("up_f_ovf", if0.ovf, 1'b0);
      step();
      chk("wrap_q", if0.q, 4'h0);
      chk("wrap_ovf", if0.ovf, 1'b1);
      step();
      chk("after_wrap_ovf", if0.ovf, 1'b0);
      setv(0, 1'b1, 1'b1, MODE_DOWN, 4'h0, 4'h0);
      step();
      step();
      chk("dwrap_q", if0.q, 4'hF);
      chk("dwrap_ovf", if0.ovf, 1'b1);

      // Stall one cycle mid-count.
      setv(0, 1'b1, 1'b1, MODE_LOAD, 4'h0, 4'h3);    step();
      setv(0, 1'b1, 1'b1, MODE_UP, 4'h0, 4'h0);      step();
      setv(0, 1'b1, 1'b0, MODE_UP, 4'h0, 4'h0);      step();
      setv(0, 1'b1, 1'b1, MODE_UP, 4'h0, 4'h0);      step();
      chk("stall_q", if0.q, 4'h5);
      setv(0, 1'b1, 1'b0, MODE_UP, 4'h0, 4'h0);

      // Saturation.
      setv(1, 1'b1, 1'b1, MODE_LOAD, 4'h0, 4'hF);    step();
      setv(1, 1'b1, 1'b1, MODE_UP, 4'h0, 4'h0);
      repeat (3) begin
         step();
         chk("sat_up_q", if1.q, 4'hF);
         chk("sat_up_ovf", if1.ovf, 1'b1);
      end
      setv(1, 1'b1, 1'b1, MODE_LOAD, 4'h0, 4'h0);    step();
      setv(1, 1'b1, 1'b1, MODE_DOWN, 4'h0, 4'h0);    step();
      chk("sat_dn_q", if1.q, 4'h0);
      chk("sat_dn_ovf", if1.ovf, 1'b1);
      setv(1, 1'b1, 1'b0, MODE_DOWN, 4'h0, 4'h0);

      // Priority corners.
      setv(0, 1'b0, 1'b1, MODE_LOAD, 4'h0, 4'h9);    step();
      chk("rst_load_q", if0.q, 4'h5);
      setv(0, 1'b1, 1'b1, MODE_LOAD, 4'h0, 4'hF);    step();
      chk("load_f_ovf", if0.ovf, 1'b0);
      setv(0, 1'b0, 1'b1, MODE_UP, 4'h0, 4'h0);      step();
      chk("rst_wrap_q", if0.q, 4'h5);
      chk("rst_wrap_ovf", if0.ovf, 1'b0);
      setv(0, 1'b1, 1'b0, MODE_UP, 4'h0, 4'h0);

      // Single-bit legacy toggle flop.
      setv(2, 1'b1, 1'b1, MODE_TOGGLE, 4'h1, 4'h0);
      step(); chk("w1_t1", if2.q, 1'b1);
      step(); chk("w1_t2", if2.q, 1'b0);
      step(); chk("w1_t3", if2.q, 1'b1);
      step(); chk("w1_t4", if2.q, 1'b0);
      setv(2, 1'b1, 1'b1, MODE_UP, 4'h0, 4'h0);      repeat (2) step();
      setv(2, 1'b1, 1'b1, MODE_DOWN, 4'h0, 4'h0);    repeat (2) step();

      // Randomized traffic on all three instances.
      for (int n = 0; n < 400; n++) begin
         for (int k = 0; k < 3; k++) begin
            setv(k, ($urandom_range(0, 24) != 0), ($urandom_range(0, 4) != 0),
                 tff_mode_t'($urandom_range(0, 3)), 4'($urandom), 4'($urandom));
         end
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
